// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and clamp helper
package bcd_pkg;
  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_counter_n_if.sv
// rtl/bcd_counter_n_if.sv - control/data bundle of the multi-digit BCD counter
interface bcd_counter_n_if #(
  parameter int DIGITS = 3
) ();
  logic                  enable;
  logic                  up;
  logic                  mode_sat;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   out;
  logic                  tc;
  logic                  ovf;

  modport master (
    output enable, up, mode_sat, load, load_val,
    input  out, tc, ovf
  );

  modport slave (
    input  enable, up, mode_sat, load, load_val,
    output out, tc, ovf
  );
endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with carry/borrow in and out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             step_in,
  input  logic             up,
  input  logic             hold,
  output logic [BCD_W-1:0] digit,
  output logic             step_out
);
  // Ripple out only when this digit is at the edge of its range in the current direction.
  assign step_out = step_in & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

  always_ff @(posedge clk) begin
    if (clear) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step_in && !hold) begin
      if (up) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end
endmodule

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - parametrised up/down BCD counter with prescaler, wrap/saturate, tc and ovf
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1
) (
  input  logic           clk,
  input  logic           clear,
  bcd_counter_n_if.slave bus
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0]         presc;
  logic                  step;
  logic [DIGITS:0]       carry;
  logic                  terminal;
  logic                  hold;
  logic [4*DIGITS-1:0]   cnt;

  assign step     = bus.enable && (presc == PMAX);
  assign carry[0] = step;
  // A carry out of the top digit means the step started from the terminal value.
  assign terminal = carry[DIGITS];
  assign hold     = bus.mode_sat & terminal;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .clear      (clear),
      .load       (bus.load),
      .load_digit (bus.load_val[4*i +: 4]),
      .step_in    (carry[i]),
      .up         (bus.up),
      .hold       (hold),
      .digit      (cnt[4*i +: 4]),
      .step_out   (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (clear || bus.load) begin
      presc   <= '0;
      bus.tc  <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      if (bus.enable) begin
        presc <= (presc == PMAX) ? '0 : presc + PW'(1);
      end
      bus.tc <= terminal;
      if (terminal) begin
        bus.ovf <= 1'b1;
      end
    end
  end

  assign bus.out = cnt;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - self-checking bench for bcd_counter_n (PRESCALE 1 and 4 side by side)
module tb_bcd_counter_n;
  localparam int D = 3;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b1;
  logic          enable = 1'b0, up = 1'b1, mode_sat = 1'b0, load = 1'b0;
  logic [11:0]   load_val = '0;

  bcd_counter_n_if #(.DIGITS(D)) if1 ();
  bcd_counter_n_if #(.DIGITS(D)) if4 ();

  assign if1.enable = enable;   assign if4.enable = enable;
  assign if1.up = up;           assign if4.up = up;
  assign if1.mode_sat = mode_sat; assign if4.mode_sat = mode_sat;
  assign if1.load = load;       assign if4.load = load;
  assign if1.load_val = load_val; assign if4.load_val = load_val;

  bcd_counter_n #(.DIGITS(D), .PRESCALE(1)) dut1 (.clk(clk), .clear(clear), .bus(if1));
  bcd_counter_n #(.DIGITS(D), .PRESCALE(4)) dut4 (.clk(clk), .clear(clear), .bus(if4));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state for both instances, value held as a plain integer
  int mP[2] = '{1, 4};
  int mv[2];
  int mp[2];
  bit mt[2];
  bit mo[2];

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = v;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [11:0] b);
    int v, w, nib;
    v = 0;
    w = 1;
    for (int d = 0; d < D; d++) begin
      nib = int'(b[4*d +: 4]);
      if (nib > 9) nib = 9;
      v += nib * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int k);
    if (clear) begin
      mv[k] = 0; mp[k] = 0; mt[k] = 0; mo[k] = 0;
    end else if (load) begin
      mv[k] = from_bcd_clamped(load_val); mp[k] = 0; mt[k] = 0; mo[k] = 0;
    end else begin
      mt[k] = 0;
      if (enable) begin
        if (mp[k] == mP[k] - 1) begin
          mp[k] = 0;
          if (up) begin
            if (mv[k] == MAXV) begin
              mt[k] = 1; mo[k] = 1;
              mv[k] = mode_sat ? MAXV : 0;
            end else mv[k] = mv[k] + 1;
          end else begin
            if (mv[k] == 0) begin
              mt[k] = 1; mo[k] = 1;
              mv[k] = mode_sat ? 0 : MAXV;
            end else mv[k] = mv[k] - 1;
          end
        end else mp[k] = mp[k] + 1;
      end
    end
  endtask

  // One clock: model sees the inputs that were present at the edge, then both DUTs are checked.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_update(0);
    model_update(1);
    chk("model_p1", {if1.ovf, if1.tc, if1.out}, {mo[0], mt[0], to_bcd(mv[0])});
    chk("model_p4", {if4.ovf, if4.tc, if4.out}, {mo[1], mt[1], to_bcd(mv[1])});
  endtask

  typedef struct {
    logic        clr, ld, en, u, sat;
    logic [11:0] lval;
    logic [11:0] eout;
    logic        etc, eovf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int tcn, tci;

    tbl[0]  = '{1,0,0,1,0,12'h000, 12'h000,0,0};
    tbl[1]  = '{0,1,0,1,0,12'h0F9, 12'h099,0,0};
    tbl[2]  = '{0,0,1,1,0,12'h000, 12'h100,0,0};
    tbl[3]  = '{0,1,1,1,0,12'h999, 12'h999,0,0};
    tbl[4]  = '{0,0,1,1,0,12'h000, 12'h000,1,1};
    tbl[5]  = '{0,0,0,1,0,12'h000, 12'h000,0,1};
    tbl[6]  = '{0,1,0,0,1,12'h000, 12'h000,0,0};
    tbl[7]  = '{0,0,1,0,1,12'h000, 12'h000,1,1};
    tbl[8]  = '{0,0,1,0,1,12'h000, 12'h000,1,1};
    tbl[9]  = '{0,0,1,0,1,12'h000, 12'h000,1,1};
    tbl[10] = '{0,1,0,1,0,12'h457, 12'h457,0,0};
    tbl[11] = '{1,1,1,1,0,12'h457, 12'h000,0,0};
    tbl[12] = '{0,1,1,0,0,12'h0A5, 12'h095,0,0};
    tbl[13] = '{0,0,1,0,0,12'h000, 12'h094,0,0};

    // reset
    clear = 1'b1;
    cycle();
    chk("reset_out", if1.out, 12'h000);
    chk("reset_tc", if1.tc, 1'b0);
    chk("reset_ovf", if1.ovf, 1'b0);

    // full up count with wrap
    clear = 1'b0; enable = 1'b1; up = 1'b1; mode_sat = 1'b0;
    tcn = 0; tci = -1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (if1.tc) begin
        tcn++;
        tci = i;
      end
    end
    chk("wrap_tc_count", tcn, 1);
    chk("wrap_tc_index", tci, 999);
    chk("wrap_out", if1.out, 12'h000);
    chk("wrap_ovf", if1.ovf, 1'b1);

    // table vectors
    for (int i = 0; i < 14; i++) begin
      clear = tbl[i].clr; load = tbl[i].ld; enable = tbl[i].en;
      up = tbl[i].u; mode_sat = tbl[i].sat; load_val = tbl[i].lval;
      cycle();
      chk($sformatf("tbl%0d_out", i), if1.out, tbl[i].eout);
      chk($sformatf("tbl%0d_tc", i), if1.tc, tbl[i].etc);
      chk($sformatf("tbl%0d_ovf", i), if1.ovf, tbl[i].eovf);
    end
    load = 1'b0;

    // prescaler hold while enable is low
    clear = 1'b1; enable = 1'b0; up = 1'b1; mode_sat = 1'b0;
    cycle();
    clear = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("presc_10", if4.out, 12'h002);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("presc_hold", if4.out, 12'h002);
    enable = 1'b1;
    cycle();
    chk("presc_11", if4.out, 12'h002);
    cycle();
    chk("presc_12", if4.out, 12'h003);

    // direction change between steps
    enable = 1'b0; load = 1'b1; load_val = 12'h098;
    cycle();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    cycle();
    chk("dir_down", if1.out, 12'h097);
    up = 1'b1;
    cycle();
    cycle();
    chk("dir_up", if1.out, 12'h099);
    chk("dir_tc", if1.tc, 1'b0);

    // randomized against the model
    for (int i = 0; i < 3000; i++) begin
      clear    = ($urandom_range(63) == 0);
      load     = ($urandom_range(15) == 0);
      enable   = ($urandom_range(3) != 0);
      up       = 1'($urandom_range(1));
      mode_sat = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: load_val = 12'h999;
        1: load_val = 12'h000;
        default: load_val = 12'($urandom);
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised multi-digit BCD counter and successor to the fixed 3-digit reaction-timer counter. It adds:
- configurable digit count
- built-in enable prescaler
- up/down counting
- synchronous BCD load
- wrap or saturate mode
- terminal-count pulse and sticky overflow flag

It feeds the 7-segment display path and times reaction intervals directly from the system clock.

Parameters:
DIGITS, 3, number of BCD digits (1..8)
PRESCALE, 1, enabled clk cycles per count step (>=1); 1 = step every enabled cycle

Ports:
clk  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset/clear
enable  input  1  count enable; prescaler advances only while high
up  input  1  1 = count up, 0 = count down
mode_sat  input  1  1 = saturate at terminal value, 0 = wrap
load  input  1  synchronous load strobe
load_val  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0]
out  output  4*DIGITS  registered BCD count; digit 0 in bits [3:0]
tc  output  1  one-cycle terminal-count pulse, registered
ovf  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (clear=1 at a clk edge):
  - out=0, prescaler=0, tc=0, ovf=0.
  - clear overrides all other inputs.
- Priority per edge: clear > load > step.
- Load:
  - Each loaded digit >9 is clamped to 9.
  - prescaler<=0, ovf<=0, tc<=0.
  - Load is accepted regardless of enable.
- Prescaler:
  - Width max(1,$clog2(PRESCALE)).
  - When enable=1: if prescaler==PRESCALE-1, a step occurs and prescaler<=0; otherwise prescaler increments.
  - When enable=0: prescaler holds and no step occurs.
  - PRESCALE=1: every enabled cycle is a step.
- Step up:
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit (ripple BCD).
  - Terminal value is all digits = 9.
- Step down:
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - Terminal value is all digits = 0.
- Step taken from the terminal value in the current direction:
  - mode_sat=0: wrap (all-9 -> 0 going up, 0 -> all-9 going down). tc=1 for exactly the next cycle; ovf<=1.
  - mode_sat=1: out holds at the terminal value. tc=1 for one cycle per attempted step; ovf<=1.
- Timing:
  - Latency: out and tc change on the same edge as the step, visible one cycle after the enabling edge.
  - tc is 0 on every cycle without a terminal step.
- ovf:
  - Set by any terminal step.
  - Cleared only by clear or load.
- Direction/mode changes: up and mode_sat are sampled at each step edge. Changing them mid-count does not reset the prescaler.
- Invalid digit states (>9) cannot arise from stepping: all arithmetic stays within 0..9 per digit, width 4 bits.
- Clear or load asserted mid-prescale discards the partial prescale count.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0
  - function bcd_clamp(digit) returning min(digit,9)
- One sub-module bcd_digit:
  - Inputs: clk, clear, load, load_digit, step_in (carry/borrow in), up, hold.
  - Outputs: digit, step_out (asserted when the digit is 9 with up, or 0 with down, and step_in=1).
  - Instantiated DIGITS times in a generate loop; step_out of digit i drives step_in of digit i+1.
- Top level owns the prescaler, terminal detection (AND of step_out chain), saturate hold, tc and ovf registers.

Test Plan:
1. DIGITS=3, PRESCALE=1, up=1, mode_sat=0, enable=1 for 1000 cycles from clear -> out steps 000..999 then 000. tc pulses exactly once, on the 999->000 edge. ovf=1 afterwards.
2. load=1, load_val=12'h0F9, then up=1 step -> loaded value 099 (F clamped to 9). Next step gives 100. tc=0, ovf=0.
3. mode_sat=1, up=0, load 000, 3 steps -> out stays 000. tc pulses on each of the 3 steps. ovf=1. A later load clears ovf.
4. PRESCALE=4, enable high for 10 cycles from clear -> out=002 (steps at cycles 4 and 8). Drop enable for 5 cycles, then raise it for 2 more -> out becomes 003 (prescaler held at 2 while enable was low).
5. Simultaneous clear=1, load=1, enable=1 with out=457 -> out=000, tc=0, ovf=0. Simultaneous load and step -> load value wins, no increment.
6. up=1 at 098, toggle up=0 before the next step -> out=097; then up=1 twice -> 099.
